// File: rtl/ysyx_25030093_lsu_axi_master.sv
// rtl/ysyx_25030093_lsu_axi_master.sv - single-beat AXI4 load/store initiator for the LSU
// One core request becomes one AXI read or write; one response is returned per request.
module ysyx_25030093_lsu_axi_master #(
   parameter logic [3:0] AXI_ID = 4'd1
) (
   input  logic        clock,
   input  logic        reset,

   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_wen,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [1:0]  req_size,
   input  logic        req_signed,

   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,

   output logic [31:0] axi_araddr,
   output logic        axi_arvalid,
   input  logic        axi_arready,
   output logic [3:0]  axi_arid,
   output logic [7:0]  axi_arlen,
   output logic [2:0]  axi_arsize,
   output logic [1:0]  axi_arburst,

   input  logic [31:0] axi_rdata,
   input  logic [1:0]  axi_rresp,
   input  logic        axi_rlast,
   input  logic [3:0]  axi_rid,
   input  logic        axi_rvalid,
   output logic        axi_rready,

   output logic [31:0] axi_awaddr,
   output logic        axi_awvalid,
   input  logic        axi_awready,
   output logic [3:0]  axi_awid,
   output logic [7:0]  axi_awlen,
   output logic [2:0]  axi_awsize,
   output logic [1:0]  axi_awburst,

   output logic [31:0] axi_wdata,
   output logic [3:0]  axi_wstrb,
   output logic        axi_wlast,
   output logic        axi_wvalid,
   input  logic        axi_wready,

   input  logic [1:0]  axi_bresp,
   input  logic [3:0]  axi_bid,
   input  logic        axi_bvalid,
   output logic        axi_bready
);

   typedef enum logic [2:0] {IDLE, RADDR, RDATA, WRITE, WRESP, RESP} state_t;

   state_t      state;
   logic [31:0] addr_q;
   logic [1:0]  size_q;
   logic        signed_q;

   logic        misaligned;
   logic [3:0]  strb_base;
   logic [3:0]  strb_next;
   logic [31:0] wdata_next;
   logic [31:0] lane;
   logic [31:0] load_ext;
   logic        aw_done;
   logic        w_done;

   assign axi_araddr  = addr_q;
   assign axi_arid    = AXI_ID;
   assign axi_arlen   = 8'd0;
   assign axi_arsize  = {1'b0, size_q};
   assign axi_arburst = 2'b01;
   assign axi_awaddr  = addr_q;
   assign axi_awid    = AXI_ID;
   assign axi_awlen   = 8'd0;
   assign axi_awsize  = {1'b0, size_q};
   assign axi_awburst = 2'b01;
   assign axi_wlast   = axi_wvalid;

   always_comb begin
      misaligned = (req_size == 2'd3)
                 | ((req_size == 2'd1) & req_addr[0])
                 | ((req_size == 2'd2) & (req_addr[1:0] != 2'b00));

      case (req_size)
         2'd0:    strb_base = 4'b0001;
         2'd1:    strb_base = 4'b0011;
         default: strb_base = 4'b1111;
      endcase
      strb_next  = strb_base << req_addr[1:0];
      wdata_next = req_wdata << {req_addr[1:0], 3'b000};

      // Load lane is shifted down to bit 0 before extension
      lane = axi_rdata >> {addr_q[1:0], 3'b000};
      case (size_q)
         2'd0:    load_ext = signed_q ? {{24{lane[7]}}, lane[7:0]}   : {24'b0, lane[7:0]};
         2'd1:    load_ext = signed_q ? {{16{lane[15]}}, lane[15:0]} : {16'b0, lane[15:0]};
         default: load_ext = lane;
      endcase

      // A channel counts as done once its valid has dropped or handshakes now
      aw_done = ~axi_awvalid | axi_awready;
      w_done  = ~axi_wvalid  | axi_wready;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= IDLE;
         req_ready   <= 1'b1;
         resp_valid  <= 1'b0;
         resp_rdata  <= 32'd0;
         resp_err    <= 1'b0;
         axi_arvalid <= 1'b0;
         axi_rready  <= 1'b0;
         axi_awvalid <= 1'b0;
         axi_wvalid  <= 1'b0;
         axi_wdata   <= 32'd0;
         axi_wstrb   <= 4'd0;
         axi_bready  <= 1'b0;
         addr_q      <= 32'd0;
         size_q      <= 2'd0;
         signed_q    <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  addr_q    <= req_addr;
                  size_q    <= req_size;
                  signed_q  <= req_signed;
                  req_ready <= 1'b0;
                  if (misaligned) begin
                     resp_valid <= 1'b1;
                     resp_err   <= 1'b1;
                     resp_rdata <= 32'd0;
                     state      <= RESP;
                  end else if (req_wen) begin
                     axi_wdata   <= wdata_next;
                     axi_wstrb   <= strb_next;
                     axi_awvalid <= 1'b1;
                     axi_wvalid  <= 1'b1;
                     state       <= WRITE;
                  end else begin
                     axi_arvalid <= 1'b1;
                     state       <= RADDR;
                  end
               end
            end
            RADDR: begin
               if (axi_arready) begin
                  axi_arvalid <= 1'b0;
                  axi_rready  <= 1'b1;
                  state       <= RDATA;
               end
            end
            RDATA: begin
               if (axi_rvalid) begin
                  axi_rready <= 1'b0;
                  resp_rdata <= load_ext;
                  resp_err   <= (axi_rresp != 2'b00) | (axi_rid != AXI_ID) | ~axi_rlast;
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            WRITE: begin
               if (axi_awready) axi_awvalid <= 1'b0;
               if (axi_wready)  axi_wvalid  <= 1'b0;
               if (aw_done && w_done) begin
                  axi_bready <= 1'b1;
                  state      <= WRESP;
               end
            end
            WRESP: begin
               if (axi_bvalid) begin
                  axi_bready <= 1'b0;
                  resp_rdata <= 32'd0;
                  resp_err   <= (axi_bresp != 2'b00) | (axi_bid != AXI_ID);
                  resp_valid <= 1'b1;
                  state      <= RESP;
               end
            end
            RESP: begin
               if (resp_ready) begin
                  resp_valid <= 1'b0;
                  resp_err   <= 1'b0;
                  req_ready  <= 1'b1;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_25030093_lsu_axi_master.sv
// tb/tb_ysyx_25030093_lsu_axi_master.sv - directed bench for the LSU AXI master
// Inputs change and outputs are observed on the falling edge.
module tb_ysyx_25030093_lsu_axi_master;

   logic        clock = 1'b0;
   logic        reset;
   logic        req_valid, req_ready, req_wen, req_signed;
   logic [31:0] req_addr, req_wdata;
   logic [1:0]  req_size;
   logic        resp_valid, resp_ready, resp_err;
   logic [31:0] resp_rdata;
   logic [31:0] axi_araddr;
   logic        axi_arvalid, axi_arready;
   logic [3:0]  axi_arid;
   logic [7:0]  axi_arlen;
   logic [2:0]  axi_arsize;
   logic [1:0]  axi_arburst;
   logic [31:0] axi_rdata;
   logic [1:0]  axi_rresp;
   logic        axi_rlast, axi_rvalid, axi_rready;
   logic [3:0]  axi_rid;
   logic [31:0] axi_awaddr;
   logic        axi_awvalid, axi_awready;
   logic [3:0]  axi_awid;
   logic [7:0]  axi_awlen;
   logic [2:0]  axi_awsize;
   logic [1:0]  axi_awburst;
   logic [31:0] axi_wdata;
   logic [3:0]  axi_wstrb;
   logic        axi_wlast, axi_wvalid, axi_wready;
   logic [1:0]  axi_bresp;
   logic [3:0]  axi_bid;
   logic        axi_bvalid, axi_bready;

   int passed = 0;
   int total  = 0;

   always #5 clock = ~clock;

   ysyx_25030093_lsu_axi_master dut (
      .clock(clock), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_wen(req_wen),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_size(req_size), .req_signed(req_signed),
      .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
      .axi_araddr(axi_araddr), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
      .axi_arid(axi_arid), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize), .axi_arburst(axi_arburst),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast), .axi_rid(axi_rid),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
      .axi_awaddr(axi_awaddr), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
      .axi_awid(axi_awid), .axi_awlen(axi_awlen), .axi_awsize(axi_awsize), .axi_awburst(axi_awburst),
      .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wlast(axi_wlast), .axi_wvalid(axi_wvalid),
      .axi_wready(axi_wready),
      .axi_bresp(axi_bresp), .axi_bid(axi_bid), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   task automatic tick;
      @(negedge clock);
   endtask

   task automatic send(input logic wen, input logic [31:0] a, input logic [31:0] wd,
                       input logic [1:0] sz, input logic sgn);
      req_wen = wen; req_addr = a; req_wdata = wd; req_size = sz; req_signed = sgn;
      req_valid = 1'b1;
      tick;
      req_valid = 1'b0;
   endtask

   task automatic wait_resp(input string tag);
      int n;
      n = 0;
      while (!resp_valid && n < 20) begin
         tick;
         n++;
      end
      chk(tag, resp_valid, 1'b1);
   endtask

   task automatic ack;
      resp_ready = 1'b1;
      tick;
      resp_ready = 1'b0;
   endtask

   initial begin
      reset = 1'b1;
      req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0; req_size = 0; req_signed = 0;
      resp_ready = 0;
      axi_arready = 0; axi_rdata = 0; axi_rresp = 0; axi_rlast = 1; axi_rid = 4'd1; axi_rvalid = 0;
      axi_awready = 0; axi_wready = 0; axi_bresp = 0; axi_bid = 4'd1; axi_bvalid = 0;
      tick; tick;
      reset = 1'b0;

      // Reset state and constant channel fields
      chk("rst_req_ready", req_ready, 1'b1);
      chk("rst_resp_valid", resp_valid, 1'b0);
      chk("rst_resp_err", resp_err, 1'b0);
      chk("rst_resp_rdata", resp_rdata, 32'd0);
      chk("rst_arvalid", axi_arvalid, 1'b0);
      chk("rst_awvalid", axi_awvalid, 1'b0);
      chk("rst_wvalid", axi_wvalid, 1'b0);
      chk("rst_rready", axi_rready, 1'b0);
      chk("rst_bready", axi_bready, 1'b0);
      chk("rst_araddr", axi_araddr, 32'd0);
      chk("rst_wdata", axi_wdata, 32'd0);
      chk("rst_wstrb", axi_wstrb, 4'd0);
      chk("arlen", axi_arlen, 8'd0);
      chk("arburst", axi_arburst, 2'b01);
      chk("awburst", axi_awburst, 2'b01);
      chk("arid", axi_arid, 4'd1);

      // Word load, zero-wait slave: latency check cycle by cycle
      axi_arready = 1; axi_rvalid = 1; axi_rdata = 32'h12345678; axi_rresp = 0; axi_rid = 4'd1; axi_rlast = 1;
      send(1'b0, 32'ha0000048, 32'd0, 2'd2, 1'b0);
      chk("lw_c1_arvalid", axi_arvalid, 1'b1);
      chk("lw_c1_araddr", axi_araddr, 32'ha0000048);
      chk("lw_c1_arsize", axi_arsize, 3'd2);
      chk("lw_c1_req_ready", req_ready, 1'b0);
      tick;
      chk("lw_c2_arvalid", axi_arvalid, 1'b0);
      chk("lw_c2_rready", axi_rready, 1'b1);
      chk("lw_c2_resp_valid", resp_valid, 1'b0);
      tick;
      chk("lw_c3_resp_valid", resp_valid, 1'b1);
      chk("lw_c3_rdata", resp_rdata, 32'h12345678);
      chk("lw_c3_err", resp_err, 1'b0);
      chk("lw_c3_rready", axi_rready, 1'b0);
      tick;
      chk("lw_hold_valid", resp_valid, 1'b1);
      chk("lw_hold_rdata", resp_rdata, 32'h12345678);
      ack;
      chk("lw_done_req_ready", req_ready, 1'b1);
      chk("lw_done_resp_valid", resp_valid, 1'b0);

      // Byte and half loads with sign/zero extension
      axi_rdata = 32'h80FFFFFF;
      send(1'b0, 32'h80000003, 32'd0, 2'd0, 1'b1);
      chk("lb_araddr", axi_araddr, 32'h80000003);
      wait_resp("lb_resp_seen");
      chk("lb_signed", resp_rdata, 32'hFFFFFF80);
      chk("lb_err", resp_err, 1'b0);
      ack;
      send(1'b0, 32'h80000003, 32'd0, 2'd0, 1'b0);
      wait_resp("lbu_resp_seen");
      chk("lbu_unsigned", resp_rdata, 32'h00000080);
      ack;
      send(1'b0, 32'h80000002, 32'd0, 2'd1, 1'b1);
      wait_resp("lh_resp_seen");
      chk("lh_signed", resp_rdata, 32'hFFFF80FF);
      ack;

      // Load with wrong RID
      axi_rid = 4'd2;
      send(1'b0, 32'h80000000, 32'd0, 2'd2, 1'b0);
      wait_resp("rid_resp_seen");
      chk("rid_err", resp_err, 1'b1);
      ack;
      axi_rid = 4'd1; axi_rvalid = 0; axi_arready = 0;

      // Store half, W ready well before AW
      axi_wready = 1; axi_awready = 0; axi_bvalid = 0; axi_bresp = 0; axi_bid = 4'd1;
      send(1'b1, 32'h80000002, 32'h0000BEEF, 2'd1, 1'b0);
      chk("sh_awvalid", axi_awvalid, 1'b1);
      chk("sh_wvalid", axi_wvalid, 1'b1);
      chk("sh_wdata", axi_wdata, 32'hBEEF0000);
      chk("sh_wstrb", axi_wstrb, 4'b1100);
      chk("sh_awsize", axi_awsize, 3'd1);
      chk("sh_wlast", axi_wlast, 1'b1);
      chk("sh_awaddr", axi_awaddr, 32'h80000002);
      tick;
      chk("sh_c2_wvalid", axi_wvalid, 1'b0);
      chk("sh_c2_awvalid", axi_awvalid, 1'b1);
      tick;
      chk("sh_c3_awvalid", axi_awvalid, 1'b1);
      tick;
      chk("sh_c4_awvalid", axi_awvalid, 1'b1);
      chk("sh_c4_bready", axi_bready, 1'b0);
      axi_awready = 1;
      tick;
      axi_awready = 0;
      chk("sh_c5_awvalid", axi_awvalid, 1'b0);
      chk("sh_c5_bready", axi_bready, 1'b1);
      axi_bvalid = 1;
      tick;
      axi_bvalid = 0;
      chk("sh_resp_valid", resp_valid, 1'b1);
      chk("sh_err", resp_err, 1'b0);
      chk("sh_rdata", resp_rdata, 32'd0);
      chk("sh_single_b", axi_bready, 1'b0);
      ack;

      // Byte store with SLVERR response
      axi_wready = 1; axi_awready = 1; axi_bvalid = 1; axi_bresp = 2'b10;
      send(1'b1, 32'h80000001, 32'h000000AB, 2'd0, 1'b0);
      chk("sb_wdata", axi_wdata, 32'h0000AB00);
      chk("sb_wstrb", axi_wstrb, 4'b0010);
      wait_resp("sb_resp_seen");
      chk("sb_bresp_err", resp_err, 1'b1);
      ack;
      axi_bvalid = 0; axi_bresp = 0; axi_wready = 0; axi_awready = 0;

      // Misaligned word load and illegal size: immediate error, no bus traffic
      send(1'b0, 32'h80000001, 32'd0, 2'd2, 1'b0);
      chk("mis_resp_valid", resp_valid, 1'b1);
      chk("mis_err", resp_err, 1'b1);
      chk("mis_arvalid", axi_arvalid, 1'b0);
      tick;
      chk("mis_arvalid_hold", axi_arvalid, 1'b0);
      chk("mis_valid_hold", resp_valid, 1'b1);
      ack;
      send(1'b1, 32'h80000000, 32'd0, 2'd3, 1'b0);
      chk("sz3_err", resp_err, 1'b1);
      chk("sz3_awvalid", axi_awvalid, 1'b0);
      chk("sz3_wvalid", axi_wvalid, 1'b0);
      ack;

      // Reset while AR is stalled
      axi_arready = 0;
      send(1'b0, 32'h80000010, 32'd0, 2'd2, 1'b0);
      for (int i = 0; i < 5; i++) begin
         chk("stall_arvalid", axi_arvalid, 1'b1);
         tick;
      end
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("mid_rst_arvalid", axi_arvalid, 1'b0);
      chk("mid_rst_req_ready", req_ready, 1'b1);
      chk("mid_rst_rready", axi_rready, 1'b0);
      chk("mid_rst_resp_valid", resp_valid, 1'b0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
